// File: rtl/byte_arb_pkg.sv
// Shared types and constants for the byte access arbiter.
// Lane geometry assumes a 32-bit word split into four byte lanes.
package byte_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE
  } arb_state_t;

  localparam int BYTE_LANES = 4;
  localparam int LANE_SEL_W = 2;

endpackage

// File: rtl/word_to_byte.sv
// Selects one byte lane of a 32-bit word using the low bits of a byte address.
module word_to_byte
  import byte_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic [ADDR_WIDTH-1:0] byte_addr_in,
  input  logic [31:0]           word_data_in,
  output logic [7:0]            byte_data_out
);

  // Only the lane-select bits matter here; the word address is the caller's business.
  logic unused_word_addr;
  assign unused_word_addr = ^byte_addr_in[ADDR_WIDTH-1:LANE_SEL_W];

  always_comb begin
    byte_data_out = '0;
    for (int l = 0; l < BYTE_LANES; l++) begin
      if (byte_addr_in[LANE_SEL_W-1:0] == LANE_SEL_W'(l)) begin
        byte_data_out = word_data_in[l*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/byte_access_arbiter.sv
// Round-robin arbiter sharing a word-wide synchronous-read memory among byte requesters.
// Define BYTE_ARB_WRITE_EN to enable byte writes via read-modify-write; otherwise every access is a read.
module byte_access_arbiter
  import byte_arb_pkg::*;
#(
  parameter int BYTE_ADDR_WIDTH = 6,
  parameter int NUM_REQ         = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*BYTE_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]               req_wdata,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
  output logic [7:0]                         rsp_data,
  output logic [BYTE_ADDR_WIDTH-3:0]         mem_addr,
  input  logic [31:0]                        mem_rdata,
  output logic [31:0]                        mem_wdata,
  output logic                               mem_we
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t                 state;
  arb_state_t                 state_next;
  logic [ID_W-1:0]            ptr;
  logic [ID_W-1:0]            ptr_next;
  logic [ID_W-1:0]            win_id;
  logic [ID_W-1:0]            cand;
  logic                       win_found;
  logic                       accept;
  logic [BYTE_ADDR_WIDTH-1:0] addr_q;
  logic [ID_W-1:0]            id_q;
  logic [7:0]                 lane_byte;

`ifdef BYTE_ARB_WRITE_EN
  logic        write_q;
  logic [7:0]  wdata_q;
  logic [31:0] merge_q;
  logic [31:0] merge_word;
`else
  logic unused_write_inputs;
  assign unused_write_inputs = ^{req_write, req_wdata};
`endif

  // Search starts at the pointer and wraps, so the requester after the last winner goes first.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    ptr_next  = ptr;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
        ptr_next  = ID_W'((int'(ptr) + k + 1) % NUM_REQ);
      end
    end
  end

  assign accept = (state == IDLE) && win_found && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready[win_id] = 1'b1;
          state_next        = ADDR;
        end
      end
      ADDR: state_next = DATA;
      DATA: begin
`ifdef BYTE_ARB_WRITE_EN
        if (write_q) begin
          state_next = WRITE;
        end else begin
          rsp_valid  = 1'b1;
          rsp_data   = lane_byte;
          state_next = IDLE;
        end
`else
        rsp_valid  = 1'b1;
        rsp_data   = lane_byte;
        state_next = IDLE;
`endif
      end
      WRITE: begin
`ifdef BYTE_ARB_WRITE_EN
        mem_we    = 1'b1;
        rsp_valid = 1'b1;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // The state register still holds the old state during the reset cycle.
    if (rst) begin
      req_ready = '0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      addr_q <= '0;
      id_q   <= '0;
`ifdef BYTE_ARB_WRITE_EN
      write_q <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
`endif
    end else begin
      if (accept) begin
        ptr    <= ptr_next;
        addr_q <= req_addr[win_id*BYTE_ADDR_WIDTH +: BYTE_ADDR_WIDTH];
        id_q   <= win_id;
`ifdef BYTE_ARB_WRITE_EN
        write_q <= req_write[win_id];
        wdata_q <= req_wdata[win_id*8 +: 8];
`endif
      end
`ifdef BYTE_ARB_WRITE_EN
      if (state == DATA && write_q) begin
        merge_q <= merge_word;
      end
`endif
    end
  end

`ifdef BYTE_ARB_WRITE_EN
  always_comb begin
    merge_word = mem_rdata;
    for (int l = 0; l < BYTE_LANES; l++) begin
      if (addr_q[LANE_SEL_W-1:0] == LANE_SEL_W'(l)) begin
        merge_word[l*8 +: 8] = wdata_q;
      end
    end
  end

  assign mem_wdata = merge_q;
`else
  assign mem_wdata = '0;
`endif

  word_to_byte #(
    .ADDR_WIDTH(BYTE_ADDR_WIDTH)
  ) u_word_to_byte (
    .byte_addr_in (addr_q),
    .word_data_in (mem_rdata),
    .byte_data_out(lane_byte)
  );

  assign mem_addr = addr_q[BYTE_ADDR_WIDTH-1:LANE_SEL_W];
  assign rsp_id   = id_q;

endmodule

// File: tb/tb_byte_access_arbiter.sv
// Directed bench for byte_access_arbiter with a grant/response scoreboard and a behavioural word memory.
// Expectations follow BYTE_ARB_WRITE_EN the same way the design does.
module tb_byte_access_arbiter;

  localparam int AW = 6;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*8-1:0] req_wdata;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic [0:0]      rsp_id;
  logic [7:0]      rsp_data;
  logic [AW-3:0]   mem_addr;
  logic [31:0]     mem_rdata;
  logic [31:0]     mem_wdata;
  logic            mem_we;

  always #5 clk = ~clk;

  byte_access_arbiter #(
    .BYTE_ADDR_WIDTH(AW),
    .NUM_REQ        (NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cycle;
  } rsp_exp_t;

  typedef struct {
    logic [3:0]  waddr;
    logic [31:0] wdata;
    int          cycle;
  } wr_exp_t;

  logic [31:0] mem_array [16];
  logic [31:0] ref_mem   [16];
  logic        load_mem;
  rsp_exp_t    rsp_q[$];
  wr_exp_t     wr_q[$];
  int          grant_log[$];
  int          cyc = 0;
  int          model_ptr = 0;
  int          next_free = 0;
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h11223344;
    if (i == 3) return 32'hDDCCBBAA;
    if (i == 5) return 32'h44332211;
    return 32'hA5A50000 | 32'(i);
  endfunction

  function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [AW-1:0] a);
    return 8'((w >> (32'(a[1:0]) * 8)) & 32'hFF);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic v, input logic wr,
                                input logic [AW-1:0] a, input logic [7:0] d);
    req_valid[idx]          = v;
    req_write[idx]          = wr;
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*8 +: 8]   = d;
  endtask

  // Word memory with one-cycle read latency
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem_array[i] <= init_word(i);
    end else if (mem_we) begin
      mem_array[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_array[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Predicts the grant each cycle and queues the expected response and memory write
  always @(negedge clk) begin : grant_monitor
    logic [NR-1:0] exp_ready;
    int            j;
    int            c;
    int            sh;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          wr;
    logic [31:0]   w;
    rsp_exp_t      re;
    wr_exp_t       we;
    exp_ready = '0;
    j = 0;
    if (rst) begin
      model_ptr = 0;
      next_free = cyc + 1;
    end else if (cyc >= next_free) begin
      for (int k = 0; k < NR; k++) begin
        c = (model_ptr + k) % NR;
        if (exp_ready == '0 && req_valid[c]) begin
          exp_ready[c] = 1'b1;
          j = c;
        end
      end
    end
    check_output("req_ready", 32'(req_ready), 32'(exp_ready));
    if (!rst && exp_ready != '0 && req_ready == exp_ready) begin
      a = req_addr[j*AW +: AW];
      d = req_wdata[j*8 +: 8];
`ifdef BYTE_ARB_WRITE_EN
      wr = req_write[j];
`else
      wr = 1'b0;
`endif
      grant_log.push_back(j);
      model_ptr = (j + 1) % NR;
      re.id = j;
      if (wr) begin
        w  = ref_mem[a[5:2]];
        sh = 8 * int'(a[1:0]);
        we.waddr = a[5:2];
        we.wdata = (w & ~(32'hFF << sh)) | (32'(d) << sh);
        we.cycle = cyc + 3;
        wr_q.push_back(we);
        re.data  = 8'h00;
        re.cycle = cyc + 3;
        next_free = cyc + 4;
      end else begin
        re.data  = lane_of(ref_mem[a[5:2]], a);
        re.cycle = cyc + 2;
        next_free = cyc + 3;
      end
      rsp_q.push_back(re);
    end
  end

  // Pops expected responses and writes as the DUT produces them
  always @(negedge clk) begin : rsp_monitor
    rsp_exp_t e;
    wr_exp_t  we;
    if (load_mem) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    end
    if (rst) begin
      rsp_q.delete();
      wr_q.delete();
      check_output("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
      check_output("mem_we_in_reset", 32'(mem_we), 32'd0);
    end else begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check_output("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check_output("rsp_id", 32'(rsp_id), 32'(e.id));
          check_output("rsp_data", 32'(rsp_data), 32'(e.data));
          check_output("rsp_cycle", 32'(cyc), 32'(e.cycle));
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].cycle <= cyc) begin
        check_output("rsp_missing", 32'(rsp_valid), 32'd1);
        void'(rsp_q.pop_front());
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          check_output("mem_we_unexpected", 32'(mem_we), 32'd0);
        end else begin
          we = wr_q.pop_front();
          check_output("mem_addr_write", 32'(mem_addr), 32'(we.waddr));
          check_output("mem_wdata", mem_wdata, we.wdata);
          check_output("mem_we_cycle", 32'(cyc), 32'(we.cycle));
          ref_mem[we.waddr] = we.wdata;
        end
      end else if (wr_q.size() > 0 && wr_q[0].cycle <= cyc) begin
        check_output("mem_we_missing", 32'(mem_we), 32'd1);
        void'(wr_q.pop_front());
      end
    end
  end

  task automatic issue_req(input int idx, input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    logic granted;
    apply_stimulus(idx, 1'b1, wr, a, d);
    granted = 1'b0;
    for (int n = 0; n < 20 && !granted; n++) begin
      @(negedge clk);
      if (req_ready[idx]) granted = 1'b1;
    end
    if (!granted) check_output("grant_timeout", 32'(req_ready[idx]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && wr_q.size() == 0) break;
    end
    check_output("drain_rsp", 32'(rsp_q.size()), 32'd0);
    check_output("drain_wr", 32'(wr_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    logic got;
    rst       = 1'b1;
    load_mem  = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    load_mem = 1'b0;

    @(negedge clk);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset_rsp_id", 32'(rsp_id), 32'd0);
    check_output("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_output("reset_mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset_mem_wdata", mem_wdata, 32'd0);
    check_output("reset_mem_we", 32'(mem_we), 32'd0);
    check_output("reset_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] read byte 0x0E by requester 0");
    issue_req(0, 1'b0, 6'h0E, 8'h00);
    wait_drain();
    check_output("mem_addr_hold", 32'(mem_addr), 32'd3);

    $display("[TB] byte write 0x99 to 0x15 by requester 1, then read back");
    issue_req(1, 1'b1, 6'h15, 8'h99);
    wait_drain();
    issue_req(0, 1'b0, 6'h15, 8'h00);
    wait_drain();

    $display("[TB] byte write to 0x00 by requester 1, then read back");
    issue_req(1, 1'b1, 6'h00, 8'h5A);
    wait_drain();
    issue_req(1, 1'b0, 6'h00, 8'h00);
    wait_drain();

    $display("[TB] contention with both requesters reading");
    start = grant_log.size();
    apply_stimulus(0, 1'b1, 1'b0, 6'h04, 8'h00);
    apply_stimulus(1, 1'b1, 1'b0, 6'h1D, 8'h00);
    for (int n = 0; n < 40 && grant_log.size() < start + 4; n++) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = '0;
    check_output("contention_grants", 32'(grant_log.size() >= start + 4), 32'd1);
    for (int k = 0; k < 4 && start + k < grant_log.size(); k++) begin
      check_output("contention_order", 32'(grant_log[start + k]), 32'(k % 2));
    end
    wait_drain();

    $display("[TB] reset during the data cycle of a write");
    issue_req(0, 1'b1, 6'h08, 8'h77);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("abort_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("abort_rsp_id", 32'(rsp_id), 32'd0);
    check_output("abort_mem_addr", 32'(mem_addr), 32'd0);
    check_output("abort_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus(0, 1'b1, 1'b0, 6'h08, 8'h00);
    apply_stimulus(1, 1'b1, 1'b0, 6'h0C, 8'h00);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    check_output("post_reset_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
